// File: rtl/bus_resp_if.sv
// Bus bundle between the CPU bus controller (master) and the memory responder (slave).
interface bus_resp_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] addr;
  logic              rd;
  logic              wr;
  logic [DATA_W-1:0] data_in;
  logic              prog_we;
  logic [ADDR_W-1:0] prog_addr;
  logic [DATA_W-1:0] prog_data;
  logic              err_clr;
  logic [DATA_W-1:0] data_out;
  logic              data_vld;
  logic              err_rom_wr;
  logic              err_unmapped;
  logic              err_conflict;
  logic [15:0]       rd_cnt;
  logic [15:0]       wr_cnt;

  modport master (
    output addr, rd, wr, data_in, prog_we, prog_addr, prog_data, err_clr,
    input  data_out, data_vld, err_rom_wr, err_unmapped, err_conflict, rd_cnt, wr_cnt
  );

  modport slave (
    input  addr, rd, wr, data_in, prog_we, prog_addr, prog_data, err_clr,
    output data_out, data_vld, err_rom_wr, err_unmapped, err_conflict, rd_cnt, wr_cnt
  );
endinterface

// File: rtl/bus_resp.sv
// ROM/RAM bus responder with sticky errors and counters; BUS_RESP_ROM_WP_EN write-protects ROM.
// Reads return 1 clk after a sampled rd; strobes are levels, never stalled (no backpressure).
module bus_resp #(
  parameter int ADDR_W    = 13,
  parameter int DATA_W    = 8,
  parameter int ROM_DEPTH = 1024,
  parameter int RAM_DEPTH = 256
) (
  input logic       clk,
  input logic       rst_n,
  bus_resp_if.slave bus
);
  localparam int ROM_AW = $clog2(ROM_DEPTH);
  localparam int RAM_AW = $clog2(RAM_DEPTH);
  localparam logic [ADDR_W-1:0] ROM_LIM = ADDR_W'(ROM_DEPTH);
  localparam logic [ADDR_W-1:0] RAM_LIM = ADDR_W'(RAM_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] rom [ROM_DEPTH];
  logic [DATA_W-1:0] ram [RAM_DEPTH];

  logic              hit_ram, hit_rom, prog_ok;
  logic              conflict, rd_op, wr_go, ram_we, rom_we, unm_err;
  logic              wr_block;
  logic [DATA_W-1:0] rdata;
  logic [DATA_W-1:0] data_out_q;
  logic              data_vld_q, err_unm_q, err_cf_q;
  logic [15:0]       rd_cnt_q, wr_cnt_q;

  assign hit_ram = (bus.addr[ADDR_W-1 -: 2] == 2'b11) &&
                   ({2'b00, bus.addr[ADDR_W-3:0]} < RAM_LIM);
  assign hit_rom = (bus.addr[ADDR_W-1 -: 2] != 2'b11) && (bus.addr < ROM_LIM);
  assign prog_ok = bus.prog_we && (bus.prog_addr < ROM_LIM);

  assign conflict = bus.rd & bus.wr;
  assign rd_op    = bus.rd & ~bus.wr;
  // wr_block keeps a strobe held across reset release from committing
  assign wr_go    = (state == IDLE) & bus.wr & ~bus.rd & ~wr_block;
  assign ram_we   = wr_go & hit_ram;
  assign unm_err  = (rd_op | wr_go) & ~hit_ram & ~hit_rom;

`ifdef BUS_RESP_ROM_WP_EN
  logic err_rom_q;
  assign rom_we = 1'b0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_rom_q <= 1'b0;
    else        err_rom_q <= (err_rom_q & ~bus.err_clr) | (wr_go & hit_rom);
  end
  assign bus.err_rom_wr = err_rom_q;
`else
  assign rom_we = wr_go & hit_rom;
  assign bus.err_rom_wr = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (hit_ram)      rdata = ram[bus.addr[RAM_AW-1:0]];
    else if (hit_rom) rdata = rom[bus.addr[ROM_AW-1:0]];
  end

  always_comb begin
    state_nxt = state;
    if (conflict) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (rd_op) state_nxt = READ;
                 else if (wr_go) state_nxt = WRITE;
        READ:    if (!bus.rd) state_nxt = IDLE;
        WRITE:   if (!bus.wr) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Program load is ordered last so it wins over a bus write to the same word
  always_ff @(posedge clk) begin
    if (ram_we)  ram[bus.addr[RAM_AW-1:0]] <= bus.data_in;
    if (rom_we)  rom[bus.addr[ROM_AW-1:0]] <= bus.data_in;
    if (prog_ok) rom[bus.prog_addr[ROM_AW-1:0]] <= bus.prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_block   <= 1'b1;
      data_out_q <= '0;
      data_vld_q <= 1'b0;
      err_unm_q  <= 1'b0;
      err_cf_q   <= 1'b0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
    end else begin
      state      <= state_nxt;
      wr_block   <= wr_block & bus.wr;
      data_vld_q <= rd_op;
      if (rd_op) data_out_q <= rdata;
      err_unm_q  <= (err_unm_q & ~bus.err_clr) | unm_err;
      err_cf_q   <= (err_cf_q & ~bus.err_clr) | conflict;
      if ((state == IDLE) && rd_op && (rd_cnt_q != 16'hFFFF)) rd_cnt_q <= rd_cnt_q + 16'd1;
      if ((ram_we || rom_we) && (wr_cnt_q != 16'hFFFF))       wr_cnt_q <= wr_cnt_q + 16'd1;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.data_vld     = data_vld_q;
  assign bus.err_unmapped = err_unm_q;
  assign bus.err_conflict = err_cf_q;
  assign bus.rd_cnt       = rd_cnt_q;
  assign bus.wr_cnt       = wr_cnt_q;
endmodule

// File: tb/tb_bus_resp.sv
// Bench for bus_resp: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model of the memories, flags and counters.
module tb_bus_resp;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 8;
`ifdef BUS_RESP_ROM_WP_EN
  localparam bit WP = 1'b1;
`else
  localparam bit WP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bus_resp_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif();
  bus_resp #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_DEPTH(1024), .RAM_DEPTH(256))
    dut (.clk(clk), .rst_n(rst_n), .bus(bif));

  int errors = 0;
  int checks = 0;

  // Behavioural model: mode 0 idle, 1 reading, 2 writing
  logic [7:0] rom_m [1024];
  logic [7:0] ram_m [256];
  int         m_mode, m_rdc, m_wrc;
  bit         m_armed, m_vld, m_erom, m_eunm, m_ecf;
  logic [7:0] m_dout;

  bit r_s, w_s;
  int a_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_armed = 0; m_dout = 8'h00; m_vld = 0;
    m_erom = 0; m_eunm = 0; m_ecf = 0; m_rdc = 0; m_wrc = 0;
  endtask

  task automatic model_step();
    int a, pa;
    bit r, w, is_ram, is_rom, commit, n_unm, n_rom;
    logic [7:0] rv;
    r = bif.rd; w = bif.wr; a = int'(bif.addr); pa = int'(bif.prog_addr);
    if (rst_n) begin
      is_ram = ((a >> 11) == 3) && ((a & 'h7FF) < 256);
      is_rom = ((a >> 11) != 3) && (a < 1024);
      rv = is_ram ? ram_m[a & 'hFF] : (is_rom ? rom_m[a & 'h3FF] : 8'h00);
      n_unm = 0; n_rom = 0;
      m_vld = r && !w;
      if (r && !w) begin
        m_dout = rv;
        if (!is_ram && !is_rom) n_unm = 1;
        if (m_mode == 0 && m_rdc < 65535) m_rdc++;
      end
      commit = (m_mode == 0) && w && !r && m_armed;
      if (commit) begin
        if (is_ram) begin
          ram_m[a & 'hFF] = bif.data_in;
          if (m_wrc < 65535) m_wrc++;
        end else if (is_rom) begin
          if (WP) n_rom = 1;
          else begin
            rom_m[a & 'h3FF] = bif.data_in;
            if (m_wrc < 65535) m_wrc++;
          end
        end else n_unm = 1;
      end
      if (r && w)          m_mode = 0;
      else if (m_mode == 0) m_mode = r ? 1 : (commit ? 2 : 0);
      else if (m_mode == 1) m_mode = r ? 1 : 0;
      else                  m_mode = w ? 2 : 0;
      if (!w) m_armed = 1;
      m_erom = (m_erom && !bif.err_clr) || n_rom;
      m_eunm = (m_eunm && !bif.err_clr) || n_unm;
      m_ecf  = (m_ecf && !bif.err_clr) || (r && w);
    end
    if (bif.prog_we && pa < 1024) rom_m[pa] = bif.prog_data;
  endtask

  task automatic check_all();
    chk("data_out", 32'(bif.data_out), 32'(m_dout));
    chk("data_vld", 32'(bif.data_vld), 32'(m_vld));
    chk("err_rom_wr", 32'(bif.err_rom_wr), 32'(m_erom));
    chk("err_unmapped", 32'(bif.err_unmapped), 32'(m_eunm));
    chk("err_conflict", 32'(bif.err_conflict), 32'(m_ecf));
    chk("rd_cnt", 32'(bif.rd_cnt), 32'(m_rdc));
    chk("wr_cnt", 32'(bif.wr_cnt), 32'(m_wrc));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic drv(input bit r, input bit w, input int a, input int d);
    bif.rd = r; bif.wr = w;
    bif.addr = ADDR_W'(a);
    bif.data_in = DATA_W'(d);
  endtask

  initial begin
    drv(0, 0, 0, 0);
    bif.prog_we = 0; bif.prog_addr = '0; bif.prog_data = '0; bif.err_clr = 0;
    rst_n = 0;
    model_reset();
    repeat (2) tick();
    rst_n = 1;
    tick();

    // Fill both memories so every later read has a defined expectation
    for (int i = 0; i < 1024; i++) begin
      bif.prog_we = 1; bif.prog_addr = ADDR_W'(i); bif.prog_data = DATA_W'($urandom);
      tick();
    end
    bif.prog_we = 0;
    for (int i = 0; i < 256; i++) begin
      drv(0, 1, 'h1800 + i, int'($urandom_range(0, 255)));
      tick();
      drv(0, 0, 'h1800 + i, 0);
      tick();
    end

    rst_n = 0;
    model_reset();
    tick();
    rst_n = 1;
    tick();
    chk("rst_data_out", 32'(bif.data_out), 0);
    chk("rst_data_vld", 32'(bif.data_vld), 0);
    chk("rst_rd_cnt", 32'(bif.rd_cnt), 0);
    chk("rst_wr_cnt", 32'(bif.wr_cnt), 0);
    chk("rst_err_conflict", 32'(bif.err_conflict), 0);

    // ROM program load then a single-cycle read
    bif.prog_we = 1; bif.prog_addr = 13'h005; bif.prog_data = 8'hA7;
    tick();
    bif.prog_we = 0;
    drv(1, 0, 'h005, 0); tick();
    chk("rom_read_data", 32'(bif.data_out), 32'h A7);
    chk("rom_read_vld", 32'(bif.data_vld), 1);
    chk("rom_read_cnt", 32'(bif.rd_cnt), 1);
    drv(0, 0, 'h005, 0); tick();
    chk("vld_drop", 32'(bif.data_vld), 0);

    // Held write commits once
    drv(0, 1, 'h1810, 'h3C); tick();
    drv(0, 1, 'h1810, 'h55); tick(); tick();
    drv(0, 0, 'h1810, 0); tick();
    chk("single_commit_cnt", 32'(bif.wr_cnt), 1);
    drv(1, 0, 'h1810, 0); tick();
    chk("single_commit_data", 32'(bif.data_out), 32'h3C);
    drv(0, 0, 'h1810, 0); tick();

    // Bus write into ROM region
    drv(0, 1, 'h005, 'hFF); tick();
    drv(0, 0, 'h005, 0); tick();
    drv(1, 0, 'h005, 0); tick();
    chk("rom_wr_data", 32'(bif.data_out), WP ? 32'hA7 : 32'hFF);
    chk("rom_wr_flag", 32'(bif.err_rom_wr), 32'(WP));
    chk("rom_wr_cnt", 32'(bif.wr_cnt), WP ? 32'd1 : 32'd2);
    drv(0, 0, 'h005, 0); tick();

    // Strobe conflict and clear priority
    drv(1, 1, 'h1810, 'h99); tick();
    chk("conflict_set", 32'(bif.err_conflict), 1);
    drv(0, 0, 'h1810, 0); tick();
    drv(1, 0, 'h1810, 0); tick();
    chk("conflict_no_write", 32'(bif.data_out), 32'h3C);
    chk("conflict_sticky", 32'(bif.err_conflict), 1);
    drv(0, 0, 'h1810, 0); tick();
    bif.err_clr = 1;
    drv(1, 1, 'h1810, 'h99); tick();
    chk("conflict_beats_clr", 32'(bif.err_conflict), 1);
    drv(0, 0, 'h1810, 0); tick();
    chk("conflict_cleared", 32'(bif.err_conflict), 0);
    bif.err_clr = 0;

    // Just past the top of RAM is unmapped
    drv(1, 0, 'h1900, 0); tick();
    chk("unmapped_data", 32'(bif.data_out), 0);
    chk("unmapped_flag", 32'(bif.err_unmapped), 1);
    drv(0, 0, 'h1900, 0); bif.err_clr = 1; tick();
    bif.err_clr = 0;

    // Reset over the write entry edge, strobe held across release
    drv(0, 1, 'h1820, 'h11); tick();
    drv(0, 0, 'h1820, 0); tick();
    drv(0, 1, 'h1820, 'h77);
    rst_n = 0;
    model_reset();
    tick();
    chk("rstw_wr_cnt", 32'(bif.wr_cnt), 0);
    chk("rstw_data_out", 32'(bif.data_out), 0);
    chk("rstw_err_unmapped", 32'(bif.err_unmapped), 0);
    rst_n = 1;
    tick(); tick();
    chk("rstw_held_no_commit", 32'(bif.wr_cnt), 0);
    drv(0, 0, 'h1820, 0); tick();
    drv(1, 0, 'h1820, 0); tick();
    chk("rstw_ram_kept", 32'(bif.data_out), 32'h11);
    drv(0, 0, 'h1820, 0); tick();

    // Randomized traffic against the model
    r_s = 0; w_s = 0; a_s = 0;
    for (int n = 0; n < 3000; n++) begin
      int k, sel;
      if ($urandom_range(0, 1) == 1) begin
        k = int'($urandom_range(0, 99));
        r_s = (k < 35);
        w_s = (k >= 30) && (k < 65);
      end
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: a_s = 'h1800 + int'($urandom_range(0, 15));
        1: a_s = int'($urandom_range(0, 15));
        2: a_s = int'($urandom_range(0, 8191));
        default: ;
      endcase
      drv(r_s, w_s, a_s, int'($urandom_range(0, 255)));
      bif.prog_we = ($urandom_range(0, 7) == 0);
      bif.prog_addr = ($urandom_range(0, 1) == 1) ? ADDR_W'(a_s) : ADDR_W'($urandom_range(0, 8191));
      bif.prog_data = DATA_W'($urandom);
      bif.err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 0;
        model_reset();
      end else begin
        rst_n = 1;
      end
      tick();
    end

    rst_n = 1;
    bif.prog_we = 0; bif.err_clr = 0;
    drv(0, 0, 0, 0);
    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bus_resp.md
# bus_resp

Memory-side responder for the RISC CPU bus: answers the controller's `rd`/`wr` strobes on the 13-bit address / 8-bit data bus and decodes each access to ROM, RAM or unmapped space. It performs registered reads, single-commit writes and a side-band ROM program load, and keeps sticky error flags and access counters. It sits between the control state machine / accumulator datapath and the program/data memories.

## Interface
- `ADDR_W`, 13, bus address width
- `DATA_W`, 8, data width
- `ROM_DEPTH`, 1024, ROM words, at address 0 upward
- `RAM_DEPTH`, 256, RAM words, based at `addr[ADDR_W-1:ADDR_W-2]==2'b11`
- `clk` input 1: single clock; all state updates on posedge.
- `rst_n` input 1: asynchronous, active-low reset.
- `addr` input ADDR_W: bus address.
- `rd` input 1: read strobe, level, from the controller.
- `wr` input 1: write strobe, level, from the controller.
- `data_in` input DATA_W: write data, valid while the controller's `data_ena` is high.
- `prog_we` input 1: ROM load strobe.
- `prog_addr` input ADDR_W: ROM load address.
- `prog_data` input DATA_W: ROM load data.
- `err_clr` input 1: clears all sticky error flags.
- `data_out` output DATA_W: read data.
- `data_vld` output 1: `data_out` holds the read of the previous cycle's address.
- `err_rom_wr` output 1: sticky flag, bus write hit ROM while protected.
- `err_unmapped` output 1: sticky flag, access to unmapped address.
- `err_conflict` output 1: sticky flag, `rd` and `wr` both high in the same cycle.
- `rd_cnt`, `wr_cnt` output 16 each: saturating access counters.

## Operation
- Decode: RAM if top two address bits are `11` and the low bits are below RAM_DEPTH. ROM if the top two bits are not `11` and `addr` is below ROM_DEPTH. Everything else is unmapped.
- FSM has three states: IDLE, READ, WRITE.
  - IDLE→READ on `rd & !wr`.
  - IDLE→WRITE on `wr & !rd`.
  - READ→IDLE on `!rd`.
  - WRITE→IDLE on `!wr`.
  - Any state→IDLE on `rd & wr`: no access, set `err_conflict`.
  - READ↔WRITE direct transitions go through the conflict/IDLE rule only; strobe swap without a low cycle is a conflict only if both are high.
- Read: every cycle `rd` is high, `addr` is sampled. On the next edge, `data_out` gets the memory word (unmapped returns 0 and sets `err_unmapped`) and `data_vld`=1. `rd_cnt` increments once per READ entry.
- Write: commits exactly once, on the IDLE→WRITE edge, using `data_in`/`addr` sampled that edge. Holding `wr` high does not rewrite. `wr_cnt` increments once per commit. Unmapped writes are dropped and set `err_unmapped`.
- `data_out` holds its last value when not reading. `data_vld` drops one edge after `rd` falls.
- `prog_we` writes ROM[`prog_addr`] every cycle it is high, regardless of FSM state or protection. If it hits the same word in the same cycle as a bus write commit, `prog_data` wins. Out-of-range `prog_addr` is ignored.
- Counters saturate at 16'hFFFF.
- `err_clr` clears flags. A new error in the same cycle wins (flag stays 1).

## Timing
- Read latency is 1 clk from a sampled `rd`. Back-to-back reads with a changing `addr` give one word per cycle.
- Write takes effect at the commit edge. A read of the same address sampled in the following cycle returns the new data.
- Reset values: FSM=IDLE, `data_out`=0, `data_vld`=0, all error flags 0, `rd_cnt`=`wr_cnt`=0. Memory contents are not reset.
- Reset asserted mid-access: the access is abandoned. A write that has not yet reached its commit edge is not committed. After release the FSM requires `wr` low→high again for a new commit.

## Configuration
- `BUS_RESP_ROM_WP_EN` defined: bus writes to the ROM region are blocked and set `err_rom_wr`. `wr_cnt` does not increment.
- Not defined: ROM region is bus-writable like RAM, `err_rom_wr` ties to 0, and blocked-write logic is absent.

## Test plan
- Program ROM[0x005]=0xA7 via `prog_we`; `rd` high 1 cycle, `addr`=0x005 → next edge `data_out`=0xA7, `data_vld`=1, `rd_cnt`=1; one edge later `data_vld`=0.
- `wr` high 3 cycles, `addr`=0x1810, `data_in`=0x3C then 0x55 → RAM[0x10]=0x3C (single commit), `wr_cnt`=1; subsequent read returns 0x3C.
- `wr` to `addr`=0x0005 with 0xFF → macro defined: ROM stays 0xA7 and `err_rom_wr`=1. Macro undefined: read returns 0xFF.
- `rd` and `wr` high together → no memory change, `err_conflict`=1 until `err_clr`. `err_clr` in the same cycle as a new conflict leaves the flag at 1.
- Read of `addr`=0x1900 (RAM_DEPTH=256) → `data_out`=0x00, `err_unmapped`=1.
- Assert `rst_n` low during the WRITE entry edge → no commit; all outputs 0 after reset.
